mac_requant_int8: RTL

- Streaming int8 multiply-accumulate stage that sits directly upstream of the ReLU activation stage.
- Consumes one signed activation/weight pair per accepted beat and accumulates exactly N_TAPS pairs plus a per-kernel bias.
- Rounds, right-shifts and saturates the sum to a signed 8-bit result.
- Presents that result on a valid/ready output whose out_data feeds the ReLU in_data directly.

---
 rtl/mac_requant_int8.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mac_requant_int8.sv
// mac_requant_int8
//   Streaming int8 multiply-accumulate with requantisation to int8.
//   Accumulates N_TAPS signed act*wgt products plus a per-kernel bias.
//   The sum is then rounded (half toward +inf), arithmetically right-shifted
//   by SHIFT and saturated to [-128,127]. The result is presented on a
//   valid/ready output that feeds a ReLU stage directly.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous abort of the partially accumulated kernel
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready (combinational)
//   in_act     signed 8-bit activation
//   in_wgt     signed 8-bit weight
//   in_bias    signed 16-bit bias, sampled on the first beat of a kernel only
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   signed saturated 8-bit result
//   busy       high while a kernel is partially accumulated
module mac_requant_int8 #(
  parameter int unsigned N_TAPS = 9,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned SHIFT  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_act,
  input  logic [7:0]  in_wgt,
  input  logic [15:0] in_bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy
);

  localparam int unsigned      TAP_W    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);
  localparam int unsigned      RND_POS  = (SHIFT == 0) ? 0 : SHIFT - 1;
  localparam logic [ACC_W-1:0] RND      = (SHIFT == 0) ? '0 : (ACC_W'(1) << RND_POS);

  typedef enum logic {
    ST_ACC,
    ST_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         data_q, data_d;

  logic signed [15:0] prod;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   bias_ext;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   acc_rnd;
  logic [ACC_W-1:0]   acc_shr;
  logic [ACC_W-8:0]   shr_upper;
  logic               in_range;
  logic [7:0]         sat8;
  logic               accept;
  logic               last_beat;

  assign prod     = $signed(in_act) * $signed(in_wgt);
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  assign bias_ext = {{(ACC_W-16){in_bias[15]}}, in_bias};

  // The first beat of a kernel starts from the bias instead of the stale accumulator.
  assign acc_base = (tap_q == '0) ? bias_ext : acc_q;
  assign acc_next = acc_base + prod_ext;
  assign acc_rnd  = acc_next + RND;
  assign acc_shr  = ACC_W'($signed(acc_rnd) >>> SHIFT);

  // Value fits in int8 iff all bits from bit 7 upward equal the sign.
  assign shr_upper = acc_shr[ACC_W-1:7];
  assign in_range  = (&shr_upper) | ~(|shr_upper);
  assign sat8      = in_range ? acc_shr[7:0] : (acc_shr[ACC_W-1] ? 8'h80 : 8'h7F);

  assign in_ready  = ~flush & ((state_q == ST_ACC) | out_ready);
  assign accept    = in_valid & in_ready;
  assign last_beat = accept & (tap_q == LAST_TAP);

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    data_d  = data_q;

    // Drain first; a final beat in the same cycle overrides back into HOLD.
    if (state_q == ST_HOLD && out_ready) begin
      state_d = ST_ACC;
    end

    if (flush) begin
      tap_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        data_d  = sat8;
        tap_d   = '0;
        state_d = ST_HOLD;
      end else begin
        acc_d = acc_next;
        tap_d = tap_q + TAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ACC;
      tap_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = data_q;
  assign busy      = (tap_q != '0);

endmodule
